// File: rtl/ahb_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_pkg
// Description : Shared definitions for the AHB slave front end and the
//               downstream address decoder: HTRANS/HSIZE encodings, the
//               front-end FSM state type and the register address map.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_slave_pkg;

    // HTRANS encodings
    localparam logic [1:0] C_HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] C_HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] C_HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] C_HTRANS_SEQ    = 2'd3;

    // HSIZE encodings (byte, halfword, word, doubleword)
    localparam logic [1:0] C_HSIZE_BYTE = 2'd0;
    localparam logic [1:0] C_HSIZE_HALF = 2'd1;
    localparam logic [1:0] C_HSIZE_WORD = 2'd2;
    localparam logic [1:0] C_HSIZE_DWRD = 2'd3;

    // Address map. The data buffer starts at address 0x0.
    localparam logic [3:0] C_ADDR_BUF_HI    = 4'h3;
    localparam logic [3:0] C_ADDR_STATUS_LO = 4'h4;
    localparam logic [3:0] C_ADDR_STATUS_HI = 4'h5;
    localparam logic [3:0] C_ADDR_ERR_LO    = 4'h6;
    localparam logic [3:0] C_ADDR_ERR_HI    = 4'h7;
    localparam logic [3:0] C_ADDR_BUF_OCC   = 4'h8;
    localparam logic [3:0] C_ADDR_TX_CTRL   = 4'hC;
    localparam logic [3:0] C_ADDR_FLUSH     = 4'hD;

    // Front-end FSM states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_WAIT = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    // Address decodes to a real register
    function automatic logic is_mapped(input logic [3:0] addr);
        return (addr <= C_ADDR_BUF_HI) ||
               ((addr >= C_ADDR_STATUS_LO) && (addr <= C_ADDR_STATUS_HI)) ||
               ((addr >= C_ADDR_ERR_LO) && (addr <= C_ADDR_ERR_HI)) ||
               (addr == C_ADDR_BUF_OCC) || (addr == C_ADDR_TX_CTRL) ||
               (addr == C_ADDR_FLUSH);
    endfunction

    // Status, error and occupancy registers cannot be written
    function automatic logic is_read_only(input logic [3:0] addr);
        return (addr >= C_ADDR_STATUS_LO) && (addr <= C_ADDR_BUF_OCC);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_access_check.sv
`default_nettype none
// ============================================================================
// Module      : ahb_access_check
// Description : Purely combinational legality check of an AHB address phase.
//   i_haddr   - transfer address
//   i_hsize   - transfer size
//   i_hwrite  - 1 = write
//   o_error   - transfer must be answered with an ERROR response
//   o_buffer  - transfer targets the data buffer (0x0-0x3)
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_access_check
    import ahb_slave_pkg::*;
(
    input  logic [3:0] i_haddr,
    input  logic [1:0] i_hsize,
    input  logic       i_hwrite,
    output logic       o_error,
    output logic       o_buffer
);

    logic w_unmapped;
    logic w_ro_write;
    logic w_misaligned;

    assign w_unmapped   = !is_mapped(i_haddr);
    assign w_ro_write   = i_hwrite && is_read_only(i_haddr);
    assign w_misaligned = (i_hsize == C_HSIZE_DWRD) ||
                          ((i_hsize == C_HSIZE_HALF) && i_haddr[0]) ||
                          ((i_hsize == C_HSIZE_WORD) && (i_haddr[1:0] != 2'b00));

    assign o_error  = w_unmapped || w_ro_write || w_misaligned;
    assign o_buffer = (i_haddr <= C_ADDR_BUF_HI);

endmodule
`default_nettype wire

// File: rtl/ahb_slave_frontend.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_frontend
// Description : AHB slave front end. Captures address phases, checks them,
//               inserts wait states for a busy data buffer, produces the
//               two-cycle ERROR response and one-cycle read/write strobes.
//   clk, n_rst            - clock, synchronous active-low reset
//   i_hsel/i_htrans/...   - AHB address-phase inputs
//   i_buffer_busy         - data buffer cannot service an access now
//   o_haddr_reg/... _reg  - captured address phase for the address decoder
//   o_write_strobe        - one-cycle write qualifier
//   o_read_strobe         - one-cycle read qualifier
//   o_hready, o_hresp     - AHB response (hresp 1 = ERROR)
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_frontend
    import ahb_slave_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       i_hsel,
    input  logic [1:0] i_htrans,
    input  logic [3:0] i_haddr,
    input  logic [1:0] i_hsize,
    input  logic       i_hwrite,
    input  logic       i_buffer_busy,
    output logic [3:0] o_haddr_reg,
    output logic [1:0] o_hsize_reg,
    output logic       o_hwrite_reg,
    output logic       o_write_strobe,
    output logic       o_read_strobe,
    output logic       o_hready,
    output logic       o_hresp
);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_haddr;
    logic [1:0] r_hsize;
    logic       r_hwrite;
    logic       r_write_strobe;
    logic       r_read_strobe;
    logic       r_hready;
    logic       r_hresp;

    logic       w_accept;
    logic       w_error;
    logic       w_buffer;
    logic       w_next_hwrite;

    ahb_access_check u_access_check (
        .i_haddr  (i_haddr),
        .i_hsize  (i_hsize),
        .i_hwrite (i_hwrite),
        .o_error  (w_error),
        .o_buffer (w_buffer)
    );

    // r_hready mirrors the current state, so it is the slave's own HREADY
    assign w_accept = i_hsel && r_hready &&
                      ((i_htrans == C_HTRANS_NONSEQ) || (i_htrans == C_HTRANS_SEQ));

    // hwrite as it will be after this edge; drives the strobe selection
    assign w_next_hwrite = w_accept ? i_hwrite : r_hwrite;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT:  w_next_state = i_buffer_busy ? S_WAIT : S_DATA;
            S_ERR1:  w_next_state = S_ERR2;
            default: begin
                if (!w_accept)
                    w_next_state = S_IDLE;
                else if (w_error)
                    w_next_state = S_ERR1;
                else if (w_buffer && i_buffer_busy)
                    w_next_state = S_WAIT;
                else
                    w_next_state = S_DATA;
            end
        endcase
    end

    // Outputs are registered from the next state so they match the state
    // register exactly in the cycle that state is occupied.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state        <= S_IDLE;
            r_haddr        <= 4'h0;
            r_hsize        <= 2'd0;
            r_hwrite       <= 1'b0;
            r_write_strobe <= 1'b0;
            r_read_strobe  <= 1'b0;
            r_hready       <= 1'b1;
            r_hresp        <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_haddr  <= i_haddr;
                r_hsize  <= i_hsize;
                r_hwrite <= i_hwrite;
            end
            r_write_strobe <= (w_next_state == S_DATA) && w_next_hwrite;
            r_read_strobe  <= (w_next_state == S_DATA) && !w_next_hwrite;
            r_hready       <= !((w_next_state == S_WAIT) || (w_next_state == S_ERR1));
            r_hresp        <= (w_next_state == S_ERR1) || (w_next_state == S_ERR2);
        end
    end

    assign o_haddr_reg    = r_haddr;
    assign o_hsize_reg    = r_hsize;
    assign o_hwrite_reg   = r_hwrite;
    assign o_write_strobe = r_write_strobe;
    assign o_read_strobe  = r_read_strobe;
    assign o_hready       = r_hready;
    assign o_hresp        = r_hresp;

endmodule
`default_nettype wire

// File: tb/tb_ahb_slave_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_frontend
// Description : Self-checking bench for ahb_slave_frontend. Directed
//               scenarios followed by random traffic, all compared against a
//               transfer-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_frontend;

    logic       clk;
    logic       n_rst;
    logic       hsel;
    logic [1:0] htrans;
    logic [3:0] haddr;
    logic [1:0] hsize;
    logic       hwrite;
    logic       busy;
    logic [3:0] haddr_reg;
    logic [1:0] hsize_reg;
    logic       hwrite_reg;
    logic       wstb;
    logic       rstb;
    logic       hready;
    logic       hresp;

    int checks = 0;
    int errors = 0;

    // Reference model: what the slave is doing with the current transfer
    logic [3:0] m_addr  = 4'h0;
    logic [1:0] m_size  = 2'd0;
    logic       m_wr    = 1'b0;
    logic       m_ws    = 1'b0;
    logic       m_rs    = 1'b0;
    logic       m_ready = 1'b1;
    logic       m_resp  = 1'b0;
    bit         m_waiting = 1'b0;
    int         m_err_left = 0;   // error response cycles still to show

    ahb_slave_frontend dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .i_hsel         (hsel),
        .i_htrans       (htrans),
        .i_haddr        (haddr),
        .i_hsize        (hsize),
        .i_hwrite       (hwrite),
        .i_buffer_busy  (busy),
        .o_haddr_reg    (haddr_reg),
        .o_hsize_reg    (hsize_reg),
        .o_hwrite_reg   (hwrite_reg),
        .o_write_strobe (wstb),
        .o_read_strobe  (rstb),
        .o_hready       (hready),
        .o_hresp        (hresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit illegal(input int a, input int sz, input bit wr);
        if (a == 9 || a == 10 || a == 11 || a == 14 || a == 15) return 1'b1;
        if (wr && a >= 4 && a <= 8) return 1'b1;
        if (sz == 3) return 1'b1;
        if (sz == 1 && (a % 2) != 0) return 1'b1;
        if (sz == 2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit acc;
        if (!n_rst) begin
            m_addr = 4'h0; m_size = 2'd0; m_wr = 1'b0;
            m_waiting = 1'b0; m_err_left = 0;
            m_ws = 1'b0; m_rs = 1'b0; m_ready = 1'b1; m_resp = 1'b0;
            return;
        end
        acc = hsel && (htrans >= 2) && m_ready;
        m_ws = 1'b0;
        m_rs = 1'b0;
        if (acc) begin
            m_addr = haddr; m_size = hsize; m_wr = hwrite;
        end
        if (m_waiting) begin
            if (!busy) begin
                m_waiting = 1'b0;
                m_ws = m_wr; m_rs = !m_wr;
            end
        end else if (m_err_left == 2) begin
            m_err_left = 1;
        end else if (acc) begin
            m_err_left = 0;
            if (illegal(int'(haddr), int'(hsize), hwrite)) m_err_left = 2;
            else if (haddr < 4 && busy) m_waiting = 1'b1;
            else begin m_ws = m_wr; m_rs = !m_wr; end
        end else begin
            m_err_left = 0;
        end
        m_ready = !(m_waiting || m_err_left == 2);
        m_resp  = (m_err_left != 0);
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("hready", {3'b0, hready}, {3'b0, m_ready});
        chk("hresp", {3'b0, hresp}, {3'b0, m_resp});
        chk("write_strobe", {3'b0, wstb}, {3'b0, m_ws});
        chk("read_strobe", {3'b0, rstb}, {3'b0, m_rs});
        chk("haddr_reg", haddr_reg, m_addr);
        chk("hsize_reg", {2'b0, hsize_reg}, {2'b0, m_size});
        chk("hwrite_reg", {3'b0, hwrite_reg}, {3'b0, m_wr});
    endtask

    // Drive one cycle of inputs (called at a falling edge), clock it, check.
    task automatic step(input bit rn, input bit s, input int tr, input int a,
                        input int sz, input bit wr, input bit b);
        n_rst  = rn;
        hsel   = s;
        htrans = 2'(tr);
        haddr  = 4'(a);
        hsize  = 2'(sz);
        hwrite = wr;
        busy   = b;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit b);
        step(1'b1, 1'b0, 0, 0, 0, 1'b0, b);
    endtask

    initial begin
        n_rst = 1'b0; hsel = 1'b0; htrans = 2'd0; haddr = 4'h0;
        hsize = 2'd0; hwrite = 1'b0; busy = 1'b0;
        @(negedge clk);

        // Reset then idle
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("reset_hready_lit", {3'b0, hready}, 4'h1);
        chk("reset_haddr_lit", haddr_reg, 4'h0);
        idle(1'b0);

        // Legal halfword read of 0x4
        step(1'b1, 1'b1, 2, 4, 1, 1'b0, 1'b0);
        chk("read_strobe_lit", {3'b0, rstb}, 4'h1);
        chk("read_addr_lit", haddr_reg, 4'h4);
        idle(1'b0);

        // Word write to 0x0 with buffer busy for three cycles
        step(1'b1, 1'b1, 2, 0, 2, 1'b1, 1'b1);
        chk("wait_hready_lit", {3'b0, hready}, 4'h0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        chk("wait_wstb_lit", {3'b0, wstb}, 4'h1);
        idle(1'b0);

        // Error responses: RO write, unmapped read, misaligned word
        step(1'b1, 1'b1, 2, 6, 0, 1'b1, 1'b0);
        chk("err1_hresp_lit", {3'b0, hresp}, 4'h1);
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 1'b1, 2, 10, 0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 1'b1, 2, 2, 2, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // Pipelined writes to 0xC then 0xD
        step(1'b1, 1'b1, 2, 12, 0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3, 13, 0, 1'b1, 1'b0);
        chk("pipe_addr_lit", haddr_reg, 4'hD);
        idle(1'b0);

        // hsel low with NONSEQ is ignored
        step(1'b1, 1'b0, 2, 5, 0, 1'b0, 1'b0);

        // Reset on the second wait cycle
        step(1'b1, 1'b1, 2, 0, 0, 1'b0, 1'b1);
        idle(1'b1);
        step(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        chk("rst_wait_hready_lit", {3'b0, hready}, 4'h1);
        idle(1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 0,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
